// File: rtl/dsp_out_buffer_pkg.sv
// Shared constants for the DSP output buffer: default geometry
// and the saturation limits of the default output width.
package dsp_out_buffer_pkg;

    localparam int DEPTH_DEF = 8;
    localparam int IN_W_DEF  = 32;
    localparam int OUT_W_DEF = 16;

    // Signed limits of an OUT_W_DEF-bit result.
    localparam int SAT_MAX = (2 ** (OUT_W_DEF - 1)) - 1;
    localparam int SAT_MIN = -(2 ** (OUT_W_DEF - 1));

    localparam int DECIM_W = 4;

endpackage

// File: rtl/dsp_sat.sv
// Combinational narrowing of a signed IN_W sample to OUT_W bits.
// Ports: din (IN_W), sat_en (1 = clamp, 0 = wrap), dout (OUT_W).
module dsp_sat
    import dsp_out_buffer_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic [IN_W-1:0]  din,
    input  logic             sat_en,
    output logic [OUT_W-1:0] dout
);

    localparam logic [OUT_W-1:0] HI = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0] LO = {1'b1, {(OUT_W - 1){1'b0}}};

    generate
        if (IN_W > OUT_W) begin : g_narrow
            logic [IN_W-OUT_W:0] top;
            logic                ovf;

            // In range only if every discarded bit equals the new sign bit.
            assign top = din[IN_W-1:OUT_W-1];
            assign ovf = !((&top) || (~|top));

            always_comb begin
                dout = din[OUT_W-1:0];
                if (sat_en && ovf) begin
                    dout = din[IN_W-1] ? LO : HI;
                end
            end
        end else begin : g_pass
            logic unused_en;
            assign unused_en = sat_en;
            assign dout      = din[OUT_W-1:0];
        end
    endgenerate

endmodule

// File: rtl/dsp_out_buffer.sv
// Decimating, saturating show-ahead FIFO behind the dsp filter.
// Ports: clk, reset (async, low), in_valid/in_sample, decim, sat_en,
// clear_ovf, out_valid/out_ready/out_data, count, full, empty,
// overflow (sticky drop flag).
module dsp_out_buffer
    import dsp_out_buffer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic signed [IN_W-1:0]     in_sample,
    input  logic [DECIM_W-1:0]         decim,
    input  logic                       sat_en,
    input  logic                       clear_ovf,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [OUT_W-1:0]    out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [OUT_W-1:0]   mem [DEPTH];
    logic [AW-1:0]      wptr;
    logic [AW-1:0]      rptr;
    logic [DECIM_W-1:0] ph;
    logic [DECIM_W-1:0] last_ph;
    logic [OUT_W-1:0]   conv;
    logic               keep;
    logic               push;
    logic               pop;
    logic               drop;

    dsp_sat #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_sat (
        .din    (in_sample),
        .sat_en (sat_en),
        .dout   (conv)
    );

    // decim==0 behaves as 1, so the last phase is 0 in both cases.
    assign last_ph = (decim == '0) ? '0 : decim - 1'b1;

    assign keep = in_valid && (ph == '0);
    assign pop  = out_valid && out_ready;
    assign push = keep && (!full || pop);
    assign drop = keep && full && !pop;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rptr];

    // Phase wraps with >= so a shrunk decim recovers on the next strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ph <= '0;
        end else if (in_valid) begin
            if (ph >= last_ph) begin
                ph <= '0;
            end else begin
                ph <= ph + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Set beats clear when both happen in one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Storage is left unreset; out_data is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= conv;
        end
    end

endmodule

// File: tb/tb_dsp_out_buffer.sv
// Directed self-checking bench for dsp_out_buffer.
// Ports: none; drives the DUT and prints one summary line.
module tb_dsp_out_buffer;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic signed [31:0] in_sample;
    logic [3:0]         decim;
    logic               sat_en;
    logic               clear_ovf;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_data;
    logic [3:0]         count;
    logic               full;
    logic               empty;
    logic               overflow;

    int checks   = 0;
    int failures = 0;

    dsp_out_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_sample (in_sample),
        .decim     (decim),
        .sat_en    (sat_en),
        .clear_ovf (clear_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int v);
        in_valid  = 1'b1;
        in_sample = v;
        step();
        in_valid  = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_sample = 0;
        decim     = 4'd1;
        sat_en    = 1'b1;
        clear_ovf = 1'b0;
        out_ready = 1'b0;
        step();
        step();

        chk("rst_valid", int'(out_valid), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_data", int'(out_data), 0);

        reset = 1'b1;
        step();

        // Basic flow, one cycle latency, streaming with out_ready=1
        out_ready = 1'b1;
        strobe(903);
        chk("s1_valid", int'(out_valid), 1);
        chk("s1_data", int'(out_data), 903);
        strobe(7258);
        chk("s2_data", int'(out_data), 7258);
        strobe(-5307);
        chk("s3_data", int'(out_data), -5307);
        chk("s3_count", int'(count), 1);
        step();
        chk("s_empty", int'(empty), 1);

        // Saturation and wrap
        strobe(40000);
        chk("sat_hi", int'(out_data), 32767);
        strobe(-40000);
        chk("sat_lo", int'(out_data), -32768);
        sat_en = 1'b0;
        strobe(40000);
        chk("wrap", int'(out_data), -25536);
        sat_en = 1'b1;
        step();
        chk("sat_empty", int'(empty), 1);

        // Decimation by 4: keeps 0, 4, 8
        out_ready = 1'b0;
        decim = 4'd4;
        for (int i = 0; i < 12; i++) strobe(i);
        chk("dec4_count", int'(count), 3);
        out_ready = 1'b1;
        chk("dec4_a", int'(out_data), 0);
        step();
        chk("dec4_b", int'(out_data), 4);
        step();
        chk("dec4_c", int'(out_data), 8);
        step();
        chk("dec4_empty", int'(empty), 1);

        // decim 4 -> 2 after sample 5: keeps 0, 4, 7, 9, 11
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 6) decim = 4'd2;
            strobe(i);
        end
        chk("dec42_count", int'(count), 5);
        out_ready = 1'b1;
        chk("dec42_a", int'(out_data), 0);
        step();
        chk("dec42_b", int'(out_data), 4);
        step();
        chk("dec42_c", int'(out_data), 7);
        step();
        chk("dec42_d", int'(out_data), 9);
        step();
        chk("dec42_e", int'(out_data), 11);
        step();
        chk("dec42_empty", int'(empty), 1);

        // ph is 1 here; decim=1 must wrap it on the next strobe, no keep
        decim = 4'd1;
        strobe(99);
        chk("shrink_nokeep", int'(empty), 1);
        strobe(98);
        chk("shrink_keep", int'(out_data), 98);
        step();

        // Overflow: 10 kept samples into 8 entries
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) strobe(100 + i);
        chk("ovf_full", int'(full), 1);
        chk("ovf_count", int'(count), 8);
        chk("ovf_flag", int'(overflow), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("ovf_drain", int'(out_data), 100 + i);
            step();
        end
        chk("ovf_empty", int'(empty), 1);
        chk("ovf_sticky", int'(overflow), 1);
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        chk("ovf_clear", int'(overflow), 0);

        // Full with simultaneous push and pop
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) strobe(200 + i);
        chk("f_full", int'(full), 1);
        step();
        chk("f_hold", int'(out_data), 200);
        out_ready = 1'b1;
        strobe(208);
        chk("f_pp_count", int'(count), 8);
        chk("f_pp_head", int'(out_data), 201);
        chk("f_pp_ovf", int'(overflow), 0);
        out_ready = 1'b0;
        clear_ovf = 1'b1;
        strobe(209);
        chk("f_set_wins", int'(overflow), 1);
        chk("f_drop_cnt", int'(count), 8);
        step();
        clear_ovf = 1'b0;
        chk("f_clr", int'(overflow), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("f_drain", int'(out_data), 201 + i);
            step();
        end
        chk("f_empty", int'(empty), 1);

        // count==1 with push and pop
        out_ready = 1'b0;
        strobe(300);
        chk("c1_count", int'(count), 1);
        out_ready = 1'b1;
        strobe(301);
        chk("c1_valid", int'(out_valid), 1);
        chk("c1_count2", int'(count), 1);
        chk("c1_data", int'(out_data), 301);
        step();
        chk("c1_empty", int'(empty), 1);

        // Asynchronous reset mid-stream, ph left at 1 beforehand
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) strobe(400 + i);
        decim = 4'd3;
        strobe(404);
        chk("ar_count5", int'(count), 5);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_valid", int'(out_valid), 0);
        chk("ar_count", int'(count), 0);
        chk("ar_data", int'(out_data), 0);
        chk("ar_ovf", int'(overflow), 0);
        step();
        reset = 1'b1;
        step();
        strobe(500);
        chk("ar_ph0", int'(out_data), 500);
        chk("ar_cnt1", int'(count), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
